// File: rtl/lock_sequencer.sv
// Canal-lock transit sequencer: arbitrates latched up/down requests, steps the chamber
// through pre-adjust, entry, adjust and exit phases, and drives the shared countdown timer.
module lock_sequencer #(
  parameter int unsigned FILL_SECS  = 420,
  parameter int unsigned DRAIN_SECS = 480,
  parameter int unsigned ENTRY_SECS = 300,
  parameter bit          RESET_HIGH = 1'b0,
  localparam int unsigned SECS_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_up,
  input  logic              req_down,
  input  logic              boat_in,
  input  logic              boat_out,
  input  logic              tmr_done,
  output logic              tmr_reset,
  output logic [SECS_W-1:0] tmr_seconds,
  output logic              tmr_start,
  output logic              gate_lo_open,
  output logic              gate_hi_open,
  output logic              fill_valve,
  output logic              drain_valve,
  output logic              level_high,
  output logic              busy,
  output logic              abort
);

  localparam logic [SECS_W-1:0] FILL_LD  = SECS_W'(FILL_SECS);
  localparam logic [SECS_W-1:0] DRAIN_LD = SECS_W'(DRAIN_SECS);
  localparam logic [SECS_W-1:0] ENTRY_LD = SECS_W'(ENTRY_SECS);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PRE_LOAD = 4'd1;
  localparam logic [3:0] S_PRE_ARM  = 4'd2;
  localparam logic [3:0] S_PRE_WAIT = 4'd3;
  localparam logic [3:0] S_ENT_LOAD = 4'd4;
  localparam logic [3:0] S_ENT_ARM  = 4'd5;
  localparam logic [3:0] S_ENT_WAIT = 4'd6;
  localparam logic [3:0] S_ADJ_LOAD = 4'd7;
  localparam logic [3:0] S_ADJ_ARM  = 4'd8;
  localparam logic [3:0] S_ADJ_WAIT = 4'd9;
  localparam logic [3:0] S_EXIT     = 4'd10;

  logic [3:0]        state, state_nxt;
  logic              dir, dir_nxt;             // 1 = transit up, 0 = transit down
  logic              pend_up, pend_up_nxt;
  logic              pend_down, pend_down_nxt;
  logic              level_nxt;
  logic              abort_nxt;
  logic              clr_up, clr_down;
  logic              tmr_reset_nxt;
  logic              tmr_start_nxt;
  logic [SECS_W-1:0] tmr_seconds_nxt;
  logic              fill_nxt, drain_nxt;
  logic              gate_lo_nxt, gate_hi_nxt;
  logic              busy_nxt;

  // State, request latches and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      dir          <= 1'b0;
      pend_up      <= 1'b0;
      pend_down    <= 1'b0;
      level_high   <= RESET_HIGH;
      abort        <= 1'b0;
      tmr_reset    <= 1'b1;
      tmr_start    <= 1'b0;
      tmr_seconds  <= '0;
      fill_valve   <= 1'b0;
      drain_valve  <= 1'b0;
      gate_lo_open <= 1'b0;
      gate_hi_open <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      dir          <= dir_nxt;
      pend_up      <= pend_up_nxt;
      pend_down    <= pend_down_nxt;
      level_high   <= level_nxt;
      abort        <= abort_nxt;
      tmr_reset    <= tmr_reset_nxt;
      tmr_start    <= tmr_start_nxt;
      tmr_seconds  <= tmr_seconds_nxt;
      fill_valve   <= fill_nxt;
      drain_valve  <= drain_nxt;
      gate_lo_open <= gate_lo_nxt;
      gate_hi_open <= gate_hi_nxt;
      busy         <= busy_nxt;
    end
  end

  // Next-state, request bookkeeping and output decode of the upcoming state
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    level_nxt = level_high;
    abort_nxt = 1'b0;
    clr_up    = 1'b0;
    clr_down  = 1'b0;

    case (state)
      S_IDLE: begin
        // With both pending, prefer the direction that needs no pre-adjust
        if (pend_up && !(pend_down && level_high)) begin
          dir_nxt   = 1'b1;
          state_nxt = level_high ? S_PRE_LOAD : S_ENT_LOAD;
        end else if (pend_down) begin
          dir_nxt   = 1'b0;
          state_nxt = level_high ? S_ENT_LOAD : S_PRE_LOAD;
        end
      end
      S_PRE_LOAD: state_nxt = S_PRE_ARM;
      S_PRE_ARM:  state_nxt = S_PRE_WAIT;
      S_PRE_WAIT: begin
        if (tmr_done) begin
          level_nxt = ~level_high;
          state_nxt = S_ENT_LOAD;
        end
      end
      S_ENT_LOAD: state_nxt = S_ENT_ARM;
      S_ENT_ARM:  state_nxt = S_ENT_WAIT;
      S_ENT_WAIT: begin
        if (boat_in) begin
          state_nxt = S_ADJ_LOAD;
        end else if (tmr_done) begin
          abort_nxt = 1'b1;
          clr_up    = dir;
          clr_down  = ~dir;
          state_nxt = S_IDLE;
        end
      end
      S_ADJ_LOAD: state_nxt = S_ADJ_ARM;
      S_ADJ_ARM:  state_nxt = S_ADJ_WAIT;
      S_ADJ_WAIT: begin
        if (tmr_done) begin
          level_nxt = ~level_high;
          state_nxt = S_EXIT;
        end
      end
      S_EXIT: begin
        if (boat_out) begin
          clr_up    = dir;
          clr_down  = ~dir;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // A new request in the same cycle as its clear survives
    pend_up_nxt   = req_up   | (pend_up   & ~clr_up);
    pend_down_nxt = req_down | (pend_down & ~clr_down);

    tmr_reset_nxt   = 1'b0;
    tmr_start_nxt   = 1'b0;
    tmr_seconds_nxt = '0;
    fill_nxt        = 1'b0;
    drain_nxt       = 1'b0;
    gate_lo_nxt     = 1'b0;
    gate_hi_nxt     = 1'b0;
    busy_nxt        = (state_nxt != S_IDLE);

    case (state_nxt)
      S_PRE_LOAD, S_PRE_ARM, S_PRE_WAIT: begin
        tmr_seconds_nxt = dir_nxt ? DRAIN_LD : FILL_LD;
        drain_nxt       = dir_nxt;
        fill_nxt        = ~dir_nxt;
      end
      S_ENT_LOAD, S_ENT_ARM, S_ENT_WAIT: begin
        tmr_seconds_nxt = ENTRY_LD;
        gate_lo_nxt     = dir_nxt;
        gate_hi_nxt     = ~dir_nxt;
      end
      S_ADJ_LOAD, S_ADJ_ARM, S_ADJ_WAIT: begin
        tmr_seconds_nxt = dir_nxt ? FILL_LD : DRAIN_LD;
        fill_nxt        = dir_nxt;
        drain_nxt       = ~dir_nxt;
      end
      S_EXIT: begin
        tmr_reset_nxt = 1'b1;
        gate_hi_nxt   = dir_nxt;
        gate_lo_nxt   = ~dir_nxt;
      end
      default: tmr_reset_nxt = 1'b1;
    endcase

    if (state_nxt == S_PRE_LOAD || state_nxt == S_ENT_LOAD || state_nxt == S_ADJ_LOAD) begin
      tmr_reset_nxt = 1'b1;
    end
    if (state_nxt == S_PRE_ARM || state_nxt == S_ENT_ARM || state_nxt == S_ADJ_ARM) begin
      tmr_start_nxt = 1'b1;
    end
  end

  // Safety invariants on the actuator commands
  a_gates_excl:  assert property (@(posedge clk) disable iff (reset) !(gate_lo_open && gate_hi_open));
  a_valves_excl: assert property (@(posedge clk) disable iff (reset) !(fill_valve && drain_valve));
  a_gate_valve:  assert property (@(posedge clk) disable iff (reset)
                   !((gate_lo_open || gate_hi_open) && (fill_valve || drain_valve)));

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: behavioural timer, transit-level reference model, randomized scenarios.
module tb_lock_sequencer;

  localparam int unsigned FILL  = 4;
  localparam int unsigned DRAIN = 5;
  localparam int unsigned ENTRY = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_up = 1'b0, req_down = 1'b0, boat_in = 1'b0, boat_out = 1'b0;
  logic       tmr_done;
  logic       tmr_reset, tmr_start;
  logic [9:0] tmr_seconds;
  logic       gate_lo_open, gate_hi_open, fill_valve, drain_valve, level_high, busy, abort;

  int checks = 0;
  int failures = 0;
  int inv_err = 0;
  bit mlevel = 1'b0;

  lock_sequencer #(
    .FILL_SECS(FILL), .DRAIN_SECS(DRAIN), .ENTRY_SECS(ENTRY), .RESET_HIGH(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .req_up(req_up), .req_down(req_down),
    .boat_in(boat_in), .boat_out(boat_out), .tmr_done(tmr_done),
    .tmr_reset(tmr_reset), .tmr_seconds(tmr_seconds), .tmr_start(tmr_start),
    .gate_lo_open(gate_lo_open), .gate_hi_open(gate_hi_open),
    .fill_valve(fill_valve), .drain_valve(drain_valve),
    .level_high(level_high), .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  // 1 Hz countdown timer: reset loads, start arms, counts down to zero and holds
  logic [9:0] tcnt = '0;
  logic       trun = 1'b0;
  always @(posedge clk) begin
    if (tmr_reset) begin
      tcnt <= tmr_seconds;
      trun <= 1'b0;
    end else if (tmr_start || trun) begin
      trun <= 1'b1;
      if (tcnt != 0) tcnt <= tcnt - 10'd1;
    end
  end
  assign tmr_done = (tcnt == 10'd0);

  always @(negedge clk) begin
    if (!reset) begin
      if ((gate_lo_open && gate_hi_open) || (fill_valve && drain_valve) ||
          ((gate_lo_open || gate_hi_open) && (fill_valve || drain_valve)) ||
          (!busy && (fill_valve || drain_valve || gate_lo_open || gate_hi_open)))
        inv_err++;
    end
  end

  typedef struct {
    int fill; int drain; int lo; int hi; int busy; int aborts; bit level;
  } exp_t;

  // Transit-level model: cycles each actuator spends open, aborts and final level
  function automatic exp_t model_transit(bit up, bit lvl, int j, int x);
    exp_t e;
    int sp_f, sp_d, sp_e, ent;
    sp_f = (FILL  == 0) ? 1 : int'(FILL);
    sp_d = (DRAIN == 0) ? 1 : int'(DRAIN);
    sp_e = (ENTRY == 0) ? 1 : int'(ENTRY);
    e = '{fill: 0, drain: 0, lo: 0, hi: 0, busy: 0, aborts: 0, level: lvl};
    if (up == lvl) begin
      if (up) e.drain += 2 + sp_d; else e.fill += 2 + sp_f;
      e.busy += 2 + (up ? sp_d : sp_f);
      e.level = ~lvl;
    end
    ent = (j <= sp_e) ? j : sp_e;
    if (up) e.lo += 2 + ent; else e.hi += 2 + ent;
    e.busy += 2 + ent;
    if (j > sp_e) begin
      e.aborts = 1;
    end else begin
      if (up) e.fill += 2 + sp_f; else e.drain += 2 + sp_d;
      e.busy += 2 + (up ? sp_f : sp_d);
      e.level = up;
      if (up) e.hi += x; else e.lo += x;
      e.busy += x;
    end
    return e;
  endfunction

  // Follow one transit: boat enters on entry-WAIT cycle j, leaves on exit cycle x
  task automatic serve(input bit up, input int j, input int x, input int exp_lat, input string tag);
    exp_t  e;
    int    act[8];
    int    exv[8];
    string nm[8] = '{"fill", "drain", "gate_lo", "gate_hi", "busy", "abort", "level", "invariant"};
    int    lo_c = 0, hi_c = 0, fill_c = 0, drain_c = 0, busy_c = 0, ab_c = 0;
    int    ew = 0, xc = 0, lat = -1;
    bit    started = 1'b0, fin = 1'b0;
    logic  lvl_end = 1'b0;
    e = model_transit(up, mlevel, j, x);
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      req_up = 1'b0; req_down = 1'b0; boat_in = 1'b0; boat_out = 1'b0;
      ab_c += int'(abort);
      if (busy) begin
        if (!started) lat = c + 1;
        started = 1'b1;
        busy_c++;
        fill_c  += int'(fill_valve);
        drain_c += int'(drain_valve);
        lo_c    += int'(gate_lo_open);
        hi_c    += int'(gate_hi_open);
        if ((up ? gate_lo_open : gate_hi_open) && !tmr_reset && !tmr_start) begin
          ew++;
          if (ew == j) boat_in = 1'b1;
        end
        if (up ? gate_hi_open : gate_lo_open) begin
          xc++;
          if (xc == x) boat_out = 1'b1;
        end
      end else if (started) begin
        fin = 1'b1;
        lvl_end = level_high;
      end
    end
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL %s completion: started=%0d finished=%0d, required finished=1", tag, started, fin);
    end
    act = '{fill_c, drain_c, lo_c, hi_c, busy_c, ab_c, int'(lvl_end), inv_err};
    exv = '{e.fill, e.drain, e.lo, e.hi, e.busy, e.aborts, int'(e.level), 0};
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (act[k] !== exv[k]) begin
        failures++;
        $display("FAIL %s %s: got %0d, expected %0d", tag, nm[k], act[k], exv[k]);
      end
    end
    if (exp_lat >= 0) begin
      checks++;
      if (lat !== exp_lat) begin
        failures++;
        $display("FAIL %s latency: got %0d, expected %0d", tag, lat, exp_lat);
      end
    end
    mlevel = e.level;
  endtask

  task automatic test_reset();
    int act[9];
    int exv[9];
    string nm[9] = '{"tmr_reset", "tmr_seconds", "tmr_start", "gate_lo", "gate_hi",
                     "fill", "drain", "level", "busy_abort"};
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      act = '{int'(tmr_reset), int'(tmr_seconds), int'(tmr_start), int'(gate_lo_open),
              int'(gate_hi_open), int'(fill_valve), int'(drain_valve), int'(level_high),
              int'(busy) + int'(abort)};
      exv = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (act[k] !== exv[k]) begin
          failures++;
          $display("FAIL reset[%0d] %s: got %0d, expected %0d", p, nm[k], act[k], exv[k]);
        end
      end
      reset = 1'b0;
      @(negedge clk);
    end
    mlevel = 1'b0;
  endtask

  task automatic test_up_from_low();
    req_up = 1'b1;
    serve(1'b1, int'($urandom_range(1, 2)), int'($urandom_range(1, 3)), 2, "up_from_low");
  endtask

  task automatic test_up_from_high();
    req_up = 1'b1;
    serve(1'b1, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 2, "up_from_high");
  endtask

  task automatic test_down();
    req_down = 1'b1;
    serve(1'b0, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 2, "down");
  endtask

  task automatic test_back_to_back();
    bit first;
    first = ~mlevel;
    req_up = 1'b1; req_down = 1'b1;
    serve(first, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 2, "both_first");
    serve(~first, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 1, "both_second");
  endtask

  task automatic test_entry_timeout();
    int quiet = 0;
    req_down = 1'b1;
    serve(1'b0, 99, 1, 2, "timeout");
    repeat (4) begin
      @(negedge clk);
      quiet += int'(busy);
    end
    checks++;
    if (quiet !== 0) begin
      failures++;
      $display("FAIL timeout_pend_cleared: busy cycles after abort %0d, expected 0", quiet);
    end
  endtask

  task automatic test_race();
    req_up = 1'b1;
    serve(1'b1, int'(ENTRY), 1, 2, "race");
  endtask

  task automatic test_random();
    bit up;
    for (int n = 0; n < 8; n++) begin
      up = 1'($urandom_range(0, 1));
      if (up) req_up = 1'b1; else req_down = 1'b1;
      serve(up, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), 2, $sformatf("random%0d", n));
    end
  endtask

  task automatic test_reset_mid();
    bit seen_gate = 1'b0, hit = 1'b0;
    int act[7];
    int exv[7];
    int quiet = 0;
    string nm[7] = '{"fill", "drain", "gates", "tmr_reset", "busy", "level", "tmr_start"};
    req_up = 1'b1;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      req_up = 1'b0; boat_in = 1'b0;
      if ((gate_lo_open || gate_hi_open) && !tmr_reset && !tmr_start) begin
        seen_gate = 1'b1;
        boat_in = 1'b1;
      end
      if (seen_gate && (fill_valve || drain_valve) && !tmr_reset && !tmr_start) begin
        hit = 1'b1;
        boat_in = 1'b0;
        reset = 1'b1;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL reset_mid reach_adjust_wait: got 0, expected 1");
    end
    @(negedge clk);
    act = '{int'(fill_valve), int'(drain_valve), int'(gate_lo_open) + int'(gate_hi_open),
            int'(tmr_reset), int'(busy), int'(level_high), int'(tmr_start)};
    exv = '{0, 0, 0, 1, 0, 0, 0};
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (act[k] !== exv[k]) begin
        failures++;
        $display("FAIL reset_mid %s: got %0d, expected %0d", nm[k], act[k], exv[k]);
      end
    end
    reset = 1'b0;
    mlevel = 1'b0;
    repeat (4) begin
      @(negedge clk);
      quiet += int'(busy);
    end
    checks++;
    if (quiet !== 0) begin
      failures++;
      $display("FAIL reset_mid pend_cleared: busy cycles %0d, expected 0", quiet);
    end
  endtask

  initial begin
    test_reset();
    test_up_from_low();
    test_up_from_high();
    test_down();
    test_back_to_back();
    test_entry_timeout();
    test_race();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
